// File: rtl/pipe_line_rx_mon_pkg.sv
// Shared definitions for the oversampling serial receive monitor:
// parity-mode encodings, receive FSM states and default parameter values.
package pipe_line_rx_mon_pkg;

    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_OVS        = 16;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ParNone    = 2'b00,
        ParEven    = 2'b01,
        ParOdd     = 2'b10,
        ParNoneAlt = 2'b11
    } par_mode_e;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2
    } rx_state_e;

    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == ParEven) || (mode == ParOdd);
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// First-word-fall-through receive buffer; head reads 0 while empty.
module rx_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_head
);

    localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push & (~o_full | i_pop);
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pipe_line_rx_mon.sv
// Oversampling serial receiver feeding a small buffer, with a last-word
// register driving an alarm comparator and a hysteretic shutdown flag.
module pipe_line_rx_mon
    import pipe_line_rx_mon_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned OVS        = DEF_OVS,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [15:0]       i_bd_div,
    input  logic [1:0]        i_par,
    input  logic              i_snum,
    input  logic              i_dout,
    input  logic              i_rd_en,
    input  logic [DATA_W-1:0] i_alarm_th,
    input  logic [DATA_W-1:0] i_shut_th,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_valid,
    output logic              o_fifo_full,
    output logic              o_overrun,
    output logic              o_parity_warning,
    output logic              o_frame_warning,
    output logic [DATA_W-1:0] o_temp_out,
    output logic              o_alarm,
    output logic              o_shutdown
);

    localparam int unsigned PH_W  = $clog2(OVS);
    localparam int unsigned BIT_W = $clog2(DATA_W);
    localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(OVS / 2 - 1);
    localparam logic [PH_W-1:0]  PH_FULL  = PH_W'(OVS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    rx_state_e         r_state;
    rx_state_e         w_state_next;
    logic [15:0]       r_tick_cnt;
    logic [15:0]       w_div_m1;
    logic              w_tick;
    logic [1:0]        r_sync;
    logic              r_rx_prev;
    logic              w_rx;
    logic              w_fall;
    logic [PH_W-1:0]   r_phase;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_par_err;
    logic              r_frm_err;
    logic              w_sample;
    logic              w_par_exp;
    logic              w_done;
    logic              w_frm_err_final;
    logic              r_push;
    logic [DATA_W-1:0] r_push_data;
    logic              w_empty;
    logic              w_full;

    assign w_div_m1 = (i_bd_div <= 16'd1) ? 16'd0 : i_bd_div - 16'd1;
    assign w_tick   = (r_tick_cnt == 16'd0);
    assign w_rx     = r_sync[1];
    assign w_fall   = r_rx_prev & ~w_rx;
    assign w_sample = w_tick && (r_state != StIdle) &&
                      (r_phase == ((r_state == StStart) ? PH_HALF : PH_FULL));
    assign w_par_exp = (i_par == ParOdd) ? ~^r_shift : ^r_shift;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tick_cnt <= '0;
            r_sync     <= 2'b11;
            r_rx_prev  <= 1'b1;
        end else begin
            r_tick_cnt <= w_tick ? w_div_m1 : r_tick_cnt - 16'd1;
            r_sync     <= {r_sync[0], i_dout};
            r_rx_prev  <= w_rx;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (w_fall) w_state_next = StStart;
            StStart:  if (w_sample) w_state_next = w_rx ? StIdle : StData;
            StData:   if (w_sample && r_bit_cnt == BIT_LAST)
                          w_state_next = par_enabled(i_par) ? StParity : StStop1;
            StParity: if (w_sample) w_state_next = StStop1;
            StStop1:  if (w_sample) w_state_next = i_snum ? StStop2 : StIdle;
            StStop2:  if (w_sample) w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    // The final stop sample is folded in here so flags load in the completion cycle.
    always_comb begin
        w_done          = 1'b0;
        w_frm_err_final = r_frm_err;
        if (w_sample && ((r_state == StStop1 && !i_snum) || r_state == StStop2)) begin
            w_done          = 1'b1;
            w_frm_err_final = r_frm_err | ~w_rx;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_phase   <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
        end else if (r_state == StIdle) begin
            r_phase   <= '0;
            r_bit_cnt <= '0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            if (w_tick) r_phase <= w_sample ? '0 : r_phase + 1'b1;
            if (w_sample) begin
                case (r_state)
                    StData: begin
                        r_shift   <= {w_rx, r_shift[DATA_W-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    StParity: r_par_err <= (w_rx != w_par_exp);
                    StStop1:  r_frm_err <= r_frm_err | ~w_rx;
                    default:  ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_parity_warning <= 1'b0;
            o_frame_warning  <= 1'b0;
            r_push           <= 1'b0;
            r_push_data      <= '0;
            o_temp_out       <= '0;
            o_overrun        <= 1'b0;
            o_alarm          <= 1'b0;
            o_shutdown       <= 1'b0;
        end else begin
            if (w_done) begin
                o_parity_warning <= r_par_err;
                o_frame_warning  <= w_frm_err_final;
            end
            r_push      <= w_done & ~r_par_err & ~w_frm_err_final;
            r_push_data <= r_shift;
            if (r_push) o_temp_out <= r_push_data;
            o_overrun <= r_push & w_full & ~i_rd_en;
            o_alarm   <= (o_temp_out >= i_alarm_th);
            if (o_temp_out >= i_shut_th)      o_shutdown <= 1'b1;
            else if (o_temp_out < i_alarm_th) o_shutdown <= 1'b0;
        end
    end

    rx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (r_push),
        .i_push_data (r_push_data),
        .i_pop       (i_rd_en),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (o_data)
    );

    assign o_data_valid = ~w_empty;
    assign o_fifo_full  = w_full;

endmodule

// File: tb/tb_pipe_line_rx_mon.sv
// Directed bench for pipe_line_rx_mon: bd_div=4, OVS=16 gives 64 clocks per bit.
module tb_pipe_line_rx_mon;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bd_div = 16'd4;
    logic [1:0]  par = 2'b00;
    logic        snum = 1'b0;
    logic        dout = 1'b1;
    logic        rd_en = 1'b0;
    logic [7:0]  alarm_th = 8'hFF;
    logic [7:0]  shut_th = 8'hFF;
    logic [7:0]  data;
    logic        data_valid, fifo_full, overrun, parity_warning, frame_warning;
    logic [7:0]  temp_out;
    logic        alarm, shutdown;

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;
    int ovr_base = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (overrun) ovr_cnt <= ovr_cnt + 1;

    pipe_line_rx_mon #(
        .DATA_W     (8),
        .OVS        (16),
        .FIFO_DEPTH (4)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_bd_div         (bd_div),
        .i_par            (par),
        .i_snum           (snum),
        .i_dout           (dout),
        .i_rd_en          (rd_en),
        .i_alarm_th       (alarm_th),
        .i_shut_th        (shut_th),
        .o_data           (data),
        .o_data_valid     (data_valid),
        .o_fifo_full      (fifo_full),
        .o_overrun        (overrun),
        .o_parity_warning (parity_warning),
        .o_frame_warning  (frame_warning),
        .o_temp_out       (temp_out),
        .o_alarm          (alarm),
        .o_shutdown       (shutdown)
    );

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic bit_time(input logic v);
        dout = v;
        repeat (64) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] w, input bit has_par, input logic pbit,
                        input bit two_stop, input logic s2);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(w[i]);
        if (has_par) bit_time(pbit);
        bit_time(1'b1);
        if (two_stop) bit_time(s2);
        dout = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_q [4];
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};

        repeat (3) @(negedge clk);
        check8("rst_data", data, 8'h00);
        check1("rst_valid", data_valid, 1'b0);
        check1("rst_full", fifo_full, 1'b0);
        check8("rst_temp", temp_out, 8'h00);
        check1("rst_alarm", alarm, 1'b0);
        check1("rst_shutdown", shutdown, 1'b0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Plain 8N1 word
        send(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
        check1("n1_valid", data_valid, 1'b1);
        check8("n1_data", data, 8'h5A);
        check8("n1_temp", temp_out, 8'h5A);
        check1("n1_pw", parity_warning, 1'b0);
        check1("n1_fw", frame_warning, 1'b0);
        pop();
        check1("n1_popped_valid", data_valid, 1'b0);
        check8("n1_popped_data", data, 8'h00);

        // Odd parity, 0x07 has three ones so parity bit 0 is correct
        par = 2'b10;
        send(8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
        check1("odd_pw", parity_warning, 1'b0);
        check8("odd_data", data, 8'h07);
        pop();

        // Even parity, same word with parity bit 0 is wrong
        par = 2'b01;
        send(8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
        check1("even_pw", parity_warning, 1'b1);
        check1("even_valid", data_valid, 1'b0);
        check8("even_temp", temp_out, 8'h07);

        // Two stop bits, second one low
        par = 2'b00;
        snum = 1'b1;
        send(8'h33, 1'b0, 1'b0, 1'b1, 1'b0);
        check1("stop2_fw", frame_warning, 1'b1);
        check1("stop2_pw", parity_warning, 1'b0);
        check1("stop2_valid", data_valid, 1'b0);
        check8("stop2_temp", temp_out, 8'h07);
        snum = 1'b0;

        // Fill and overflow the buffer
        ovr_base = ovr_cnt;
        for (int i = 0; i < 4; i++) send(exp_q[i], 1'b0, 1'b0, 1'b0, 1'b1);
        check1("fill_full", fifo_full, 1'b1);
        check8("fill_ovr", 8'(ovr_cnt - ovr_base), 8'd0);
        send(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        check8("ovf_ovr", 8'(ovr_cnt - ovr_base), 8'd1);
        check1("ovf_full", fifo_full, 1'b1);
        check8("ovf_head", data, 8'h11);
        check8("ovf_temp", temp_out, 8'h55);
        for (int i = 0; i < 4; i++) begin
            check8("drain_head", data, exp_q[i]);
            pop();
        end
        check1("drain_valid", data_valid, 1'b0);

        // Thresholds applied once temp_out is 60 so shutdown starts clear
        send(8'd60, 1'b0, 1'b0, 1'b0, 1'b1);
        alarm_th = 8'd50;
        shut_th  = 8'd80;
        repeat (3) @(negedge clk);
        check1("t60_alarm", alarm, 1'b1);
        check1("t60_shut", shutdown, 1'b0);
        send(8'd85, 1'b0, 1'b0, 1'b0, 1'b1);
        check1("t85_alarm", alarm, 1'b1);
        check1("t85_shut", shutdown, 1'b1);
        send(8'd70, 1'b0, 1'b0, 1'b0, 1'b1);
        check1("t70_alarm", alarm, 1'b1);
        check1("t70_shut", shutdown, 1'b1);
        send(8'd40, 1'b0, 1'b0, 1'b0, 1'b1);
        check1("t40_alarm", alarm, 1'b0);
        check1("t40_shut", shutdown, 1'b0);

        // Two-tick glitch must not produce a word
        dout = 1'b0;
        repeat (8) @(negedge clk);
        dout = 1'b1;
        repeat (100) @(negedge clk);
        check8("glitch_head", data, 8'd60);
        check1("glitch_full", fifo_full, 1'b1);
        check8("glitch_temp", temp_out, 8'd40);

        // Reset in the middle of a frame
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b0);
        rst  = 1'b1;
        dout = 1'b1;
        @(negedge clk);
        check8("mid_rst_data", data, 8'h00);
        check1("mid_rst_valid", data_valid, 1'b0);
        check1("mid_rst_full", fifo_full, 1'b0);
        check8("mid_rst_temp", temp_out, 8'h00);
        check1("mid_rst_pw", parity_warning, 1'b0);
        check1("mid_rst_fw", frame_warning, 1'b0);
        check1("mid_rst_alarm", alarm, 1'b0);
        rst = 1'b0;
        repeat (700) @(negedge clk);
        check1("post_rst_valid", data_valid, 1'b0);
        check8("post_rst_temp", temp_out, 8'h00);
        check1("post_rst_shut", shutdown, 1'b0);
        check1("post_rst_ovr", overrun, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_line_rx_mon.md
PIPE_LINE_RX_MON -- requirements
Module: pipe_line_rx_mon

Interface
REQ-001 Parameter DATA_W, default 8, received word width, legal 5..9.
REQ-002 Parameter OVS, default 16, oversample ticks per bit, even, legal 8..32.
REQ-003 Parameter FIFO_DEPTH, default 4, receive buffer entries, power of two, legal 2..64.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 bd_div  input  16  clk cycles per oversample tick; 0 and 1 both treated as 1.
REQ-007 par  input  2  parity mode: 00 none, 01 even, 10 odd, 11 none.
REQ-008 snum  input  1  stop bits: 0 one, 1 two.
REQ-009 dout  input  1  serial line, idle high, asynchronous to clk.
REQ-010 rd_en  input  1  pop FIFO head.
REQ-011 alarm_th, shut_th  input  DATA_W each  alarm and shutdown thresholds, unsigned.
REQ-012 data  output  DATA_W  FIFO head, first-word fall-through; 0 when empty.
REQ-013 data_valid  output  1  FIFO not empty.
REQ-014 fifo_full  output  1  FIFO holds FIFO_DEPTH words.
REQ-015 overrun  output  1  one-cycle pulse when a good word is dropped.
REQ-016 parity_warning, frame_warning  output  1 each  status of last completed frame.
REQ-017 temp_out  output  DATA_W  last good word received.
REQ-018 alarm, shutdown  output  1 each  threshold controller outputs.

Function
REQ-019 Tick counter reloads to bd_div-1, asserts tick for one clk at zero; free-running.
REQ-020 dout passes a 2-flop synchroniser; all receive logic uses the synchronised value.
REQ-021 Receive FSM states IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-022 IDLE -> START on synchronised falling edge; tick phase counter cleared.
REQ-023 START samples at OVS/2 ticks; line high -> IDLE (glitch), low -> DATA.
REQ-024 DATA samples every OVS ticks, LSB first, DATA_W bits -> PARITY if par is 01/10, else STOP1.
REQ-025 PARITY samples one bit; mismatch with even/odd over data bits sets parity error.
REQ-026 STOP1 samples; low sets frame error; -> STOP2 if snum=1, else frame completes.
REQ-027 STOP2 samples; low sets frame error; frame completes.
REQ-028 On completion parity_warning and frame_warning load the frame's error flags, held until next completion; FSM -> IDLE same cycle.
REQ-029 Good word (no errors) pushed to FIFO and loaded into temp_out the cycle after completion; errored word discarded.
REQ-030 Push when full and no rd_en: word dropped, overrun pulses, temp_out still updates.
REQ-031 Push and rd_en same cycle when full: both occur, no overrun; when empty: push only, rd_en ignored.
REQ-032 rd_en when empty ignored; pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-033 alarm registered: 1 iff temp_out >= alarm_th, re-evaluated every cycle.
REQ-034 shutdown sets when temp_out >= shut_th; clears only when temp_out < alarm_th (hysteresis); else holds.
REQ-035 Changing par, snum, bd_div mid-frame has undefined frame result but FSM returns to IDLE within one frame time.

Reset
REQ-036 rst forces: FSM IDLE, tick and phase counters 0, synchroniser 1s, FIFO empty, all outputs 0.
REQ-037 Reset mid-frame discards the partial word; no push, no flag update.

Structure
REQ-038 Shared package holds parity-mode encodings, FSM state enum, default parameter constants.
REQ-039 FIFO is sub-module rx_fifo (DATA_W, FIFO_DEPTH), push/pop/full/empty/head.

Verification
REQ-040 bd_div=4, OVS=16, par=00, snum=0, send 0x5A -> data_valid after frame, data=0x5A, temp_out=0x5A, warnings 0.
REQ-041 par=01, send 0x07 with parity bit 0 -> parity_warning=1, no push, temp_out unchanged.
REQ-042 snum=1, second stop bit low, word 0x33 -> frame_warning=1, FIFO count unchanged.
REQ-043 Send 5 good words, no rd_en, FIFO_DEPTH=4 -> fifo_full=1, one overrun pulse on 5th, head = 1st word.
REQ-044 alarm_th=50, shut_th=80: words 60, 85, 70, 40 -> alarm 1,1,1,0; shutdown 0,1,1,0.
REQ-045 2-tick low glitch on dout then assert rst mid-frame -> FSM IDLE, no push, all outputs 0.
